// File: rtl/alu_multicycle.sv
// alu_multicycle: EX-stage execution unit. Logic, add/sub, shift and compare ops finish in
// one cycle; MUL (shift-add) and DIV (restoring) iterate once per cycle behind a busy/done handshake.
`default_nettype none

module alu_multicycle #(
   parameter int WIDTH = 32,
   parameter int ITER  = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [3:0]       alu_op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic             zero,
   output logic             ovf,
   output logic             div0,
   output logic             illegal
);

   localparam int CW = $clog2(ITER);
   localparam logic [3:0] c_OP_ADD = 4'b0000, c_OP_SUB = 4'b0001, c_OP_MUL = 4'b0010,
                          c_OP_DIV = 4'b0011, c_OP_AND = 4'b0100, c_OP_OR  = 4'b0101,
                          c_OP_NOR = 4'b0110, c_OP_NOP = 4'b0111, c_OP_SRL = 4'b1000,
                          c_OP_SLT = 4'b1001, c_OP_XOR = 4'b1010;

   typedef enum logic [1:0] {S_IDLE, S_MUL_RUN, S_DIV_RUN, S_FINISH} state_t;

   state_t           r_state;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_hi, r_lo, r_opnd;
   logic             r_neg_q, r_neg_r, r_is_div, r_div0_pend;
   logic             r_busy, r_done, r_zero, r_ovf, r_div0, r_illegal;
   logic [WIDTH-1:0] r_result, r_result_hi;

   logic [WIDTH-1:0] w_sum, w_diff, w_res, w_mag_a, w_mag_b, w_div_shift;
   logic [WIDTH-1:0] w_fin_lo, w_fin_hi;
   logic [WIDTH:0]   w_mul_sum, w_div_trial;
   logic             w_ovf, w_ill;

   always_comb begin
      w_sum  = a + b;
      w_diff = a - b;
      w_res  = '0;
      w_ovf  = 1'b0;
      w_ill  = 1'b0;
      case (alu_op)
         c_OP_ADD: begin
            w_res = w_sum;
            w_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
         end
         c_OP_SUB: begin
            w_res = w_diff;
            w_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
         end
         c_OP_AND: w_res = a & b;
         c_OP_OR:  w_res = a | b;
         c_OP_NOR: w_res = ~(a | b);
         c_OP_XOR: w_res = a ^ b;
         c_OP_SRL: w_res = a >> b[4:0];
         c_OP_SLT: w_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         c_OP_NOP, c_OP_MUL, c_OP_DIV: w_res = '0;
         default:  w_ill = 1'b1;
      endcase
   end

   assign w_mag_a = a[WIDTH-1] ? (~a + 1'b1) : a;
   assign w_mag_b = b[WIDTH-1] ? (~b + 1'b1) : b;

   // MUL: multiplier sits in r_lo and shifts out LSB-first while the product shifts in.
   assign w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
   // DIV: dividend shifts out of r_lo MSB-first into the partial remainder, quotient bits shift in.
   assign w_div_shift = {r_hi[WIDTH-2:0], r_lo[WIDTH-1]};
   assign w_div_trial = {1'b0, w_div_shift} - {1'b0, r_opnd};

   always_comb begin
      w_fin_lo = r_lo;
      w_fin_hi = r_hi;
      if (r_is_div) begin
         if (r_div0_pend) begin
            w_fin_lo = '1;
            w_fin_hi = r_lo;
         end else begin
            w_fin_lo = r_neg_q ? (~r_lo + 1'b1) : r_lo;
            w_fin_hi = r_neg_r ? (~r_hi + 1'b1) : r_hi;
         end
      end else if (r_neg_q) begin
         {w_fin_hi, w_fin_lo} = ~{r_hi, r_lo} + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_hi        <= '0;
         r_lo        <= '0;
         r_opnd      <= '0;
         r_neg_q     <= 1'b0;
         r_neg_r     <= 1'b0;
         r_is_div    <= 1'b0;
         r_div0_pend <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_zero      <= 1'b0;
         r_ovf       <= 1'b0;
         r_div0      <= 1'b0;
         r_illegal   <= 1'b0;
         r_result    <= '0;
         r_result_hi <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  case (alu_op)
                     c_OP_MUL: begin
                        r_opnd   <= w_mag_a;
                        r_lo     <= w_mag_b;
                        r_hi     <= '0;
                        r_neg_q  <= a[WIDTH-1] ^ b[WIDTH-1];
                        r_is_div <= 1'b0;
                        r_div0_pend <= 1'b0;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= S_MUL_RUN;
                     end
                     c_OP_DIV: begin
                        r_hi     <= '0;
                        r_neg_q  <= a[WIDTH-1] ^ b[WIDTH-1];
                        r_neg_r  <= a[WIDTH-1];
                        r_is_div <= 1'b1;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        if (b == '0) begin
                           r_div0_pend <= 1'b1;
                           r_lo        <= a;
                           r_state     <= S_FINISH;
                        end else begin
                           r_div0_pend <= 1'b0;
                           r_opnd      <= w_mag_b;
                           r_lo        <= w_mag_a;
                           r_state     <= S_DIV_RUN;
                        end
                     end
                     default: begin
                        r_result    <= w_res;
                        r_result_hi <= '0;
                        r_zero      <= (w_res == '0);
                        r_ovf       <= w_ovf;
                        r_div0      <= 1'b0;
                        r_illegal   <= w_ill;
                        r_done      <= 1'b1;
                     end
                  endcase
               end
            end
            S_MUL_RUN: begin
               r_hi  <= w_mul_sum[WIDTH:1];
               r_lo  <= {w_mul_sum[0], r_lo[WIDTH-1:1]};
               r_cnt <= r_cnt + CW'(1);
               if (r_cnt == CW'(ITER-1)) r_state <= S_FINISH;
            end
            S_DIV_RUN: begin
               r_hi  <= w_div_trial[WIDTH] ? w_div_shift : w_div_trial[WIDTH-1:0];
               r_lo  <= {r_lo[WIDTH-2:0], ~w_div_trial[WIDTH]};
               r_cnt <= r_cnt + CW'(1);
               if (r_cnt == CW'(ITER-1)) r_state <= S_FINISH;
            end
            S_FINISH: begin
               r_result    <= w_fin_lo;
               r_result_hi <= w_fin_hi;
               r_zero      <= (w_fin_lo == '0);
               r_ovf       <= 1'b0;
               r_div0      <= r_div0_pend;
               r_illegal   <= 1'b0;
               r_busy      <= 1'b0;
               r_done      <= 1'b1;
               r_state     <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy      = r_busy;
   assign done      = r_done;
   assign result    = r_result;
   assign result_hi = r_result_hi;
   assign zero      = r_zero;
   assign ovf       = r_ovf;
   assign div0      = r_div0;
   assign illegal   = r_illegal;

endmodule

`default_nettype wire

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle: directed self-checking bench for alu_multicycle.
`default_nettype none

module tb_alu_multicycle;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [3:0]  alu_op;
   logic [31:0] a, b;
   logic        busy, done, zero, ovf, div0, illegal;
   logic [31:0] result, result_hi;

   int checks = 0;
   int errors = 0;
   int lat, bc, seen;

   alu_multicycle #(.WIDTH(32), .ITER(32)) dut (
      .clk(clk), .rst(rst), .start(start), .alu_op(alu_op), .a(a), .b(b),
      .busy(busy), .done(done), .result(result), .result_hi(result_hi),
      .zero(zero), .ovf(ovf), .div0(div0), .illegal(illegal)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Issues one op and returns the start-edge-to-done latency and the number of busy cycles.
   task automatic run_op(input logic [3:0] op, input logic [31:0] va, input logic [31:0] vb,
                         output int l, output int bcount);
      @(negedge clk);
      start = 1'b1; alu_op = op; a = va; b = vb;
      @(posedge clk); #1;
      start = 1'b0;
      l = 1; bcount = 0;
      while (done !== 1'b1 && l < 100) begin
         if (busy === 1'b1) bcount++;
         @(posedge clk); #1;
         l++;
      end
   endtask

   always @(negedge clk) begin
      if (rst === 1'b0) begin
         checks++;
         assert (!(done === 1'b1 && busy === 1'b1))
         else begin
            errors++;
            $error("FAIL done_busy_overlap observed=1 expected=0");
         end
      end
   end

   initial begin
      rst = 1'b1; start = 1'b0; alu_op = 4'd0; a = '0; b = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_result", result, 32'h0);
      chk("rst_result_hi", result_hi, 32'h0);
      chk("rst_flags", {26'b0, busy, done, zero, ovf, div0, illegal}, 32'h0);
      @(negedge clk) rst = 1'b0;

      run_op(4'b0000, 32'h7FFF_FFFF, 32'h1, lat, bc);
      chk("add_lat", lat, 1);
      chk("add_res", result, 32'h8000_0000);
      chk("add_ovf_zero", {30'b0, ovf, zero}, 32'h2);

      run_op(4'b0001, 32'd5, 32'd5, lat, bc);
      chk("sub_res", result, 32'h0);
      chk("sub_ovf_zero", {30'b0, ovf, zero}, 32'h1);

      run_op(4'b0001, 32'h8000_0000, 32'h1, lat, bc);
      chk("sub_ovf_res", result, 32'h7FFF_FFFF);
      chk("sub_ovf_flag", {31'b0, ovf}, 32'h1);

      run_op(4'b1001, 32'hFFFF_FFFF, 32'h1, lat, bc);
      chk("slt_res", result, 32'h1);
      chk("slt_ovf_cleared", {31'b0, ovf}, 32'h0);
      run_op(4'b1000, 32'h8000_0000, 32'd31, lat, bc);
      chk("srl_res", result, 32'h1);

      run_op(4'b0100, 32'hF0F0_00FF, 32'h0FF0_0F0F, lat, bc);
      chk("and_res", result, 32'h00F0_000F);
      run_op(4'b0101, 32'hF0F0_00FF, 32'h0FF0_0F0F, lat, bc);
      chk("or_res", result, 32'hFFF0_0FFF);
      run_op(4'b0110, 32'hF0F0_00FF, 32'h0FF0_0F0F, lat, bc);
      chk("nor_res", result, 32'h000F_F000);
      run_op(4'b1010, 32'hF0F0_00FF, 32'h0FF0_0F0F, lat, bc);
      chk("xor_res", result, 32'hFF00_0FF0);

      run_op(4'b0010, 32'hFFFF_FFFD, 32'd7, lat, bc);
      chk("mul_lat", lat, 34);
      chk("mul_busy_cycles", bc, 33);
      chk("mul_lo", result, 32'hFFFF_FFEB);
      chk("mul_hi", result_hi, 32'hFFFF_FFFF);

      run_op(4'b0010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bc);
      chk("mul_m1_lo", result, 32'h1);
      chk("mul_m1_hi", result_hi, 32'h0);
      run_op(4'b0010, 32'h1234_5678, 32'h10, lat, bc);
      chk("mul_pos_lo", result, 32'h2345_6780);
      chk("mul_pos_hi", result_hi, 32'h1);

      run_op(4'b0011, 32'hFFFF_FFF9, 32'd2, lat, bc);
      chk("div_lat", lat, 34);
      chk("div_q", result, 32'hFFFF_FFFD);
      chk("div_r", result_hi, 32'hFFFF_FFFF);
      run_op(4'b0011, 32'd100, 32'd7, lat, bc);
      chk("div_pos_q", result, 32'd14);
      chk("div_pos_r", result_hi, 32'd2);

      run_op(4'b0011, 32'd9, 32'd0, lat, bc);
      chk("div0_lat", lat, 2);
      chk("div0_q", result, 32'hFFFF_FFFF);
      chk("div0_r", result_hi, 32'd9);
      chk("div0_flag", {31'b0, div0}, 32'h1);

      run_op(4'b0011, 32'h8000_0000, 32'hFFFF_FFFF, lat, bc);
      chk("divovf_q", result, 32'h8000_0000);
      chk("divovf_r", result_hi, 32'h0);
      chk("divovf_flags", {30'b0, ovf, div0}, 32'h0);

      run_op(4'b0111, 32'd3, 32'd4, lat, bc);
      chk("nop_lat", lat, 1);
      chk("nop_res", result, 32'h0);
      chk("nop_zero", {31'b0, zero}, 32'h1);

      run_op(4'b1111, 32'd3, 32'd4, lat, bc);
      chk("ill_lat", lat, 1);
      chk("ill_res", {result | result_hi}, 32'h0);
      chk("ill_flag", {31'b0, illegal}, 32'h1);
      run_op(4'b0000, 32'd1, 32'd2, lat, bc);
      chk("ill_clear_res", result, 32'd3);
      chk("ill_clear_flag", {31'b0, illegal}, 32'h0);

      // MUL with an ADD request arriving mid-flight; operands also change under busy.
      @(negedge clk);
      start = 1'b1; alu_op = 4'b0010; a = 32'hFFFF_FFFD; b = 32'd7;
      @(posedge clk); #1;
      start = 1'b0; lat = 1;
      while (done !== 1'b1 && lat < 100) begin
         if (lat == 9) begin
            @(negedge clk);
            start = 1'b1; alu_op = 4'b0000; a = 32'd1; b = 32'd1;
            @(posedge clk); #1;
            start = 1'b0;
         end else begin
            @(posedge clk); #1;
         end
         lat++;
      end
      chk("mul_ign_lat", lat, 34);
      chk("mul_ign_lo", result, 32'hFFFF_FFEB);
      chk("mul_ign_hi", result_hi, 32'hFFFF_FFFF);

      // Reset in the middle of a second MUL.
      @(negedge clk);
      start = 1'b1; alu_op = 4'b0010; a = 32'h1234_5678; b = 32'h10;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (19) @(posedge clk);
      @(negedge clk) rst = 1'b1;
      #1;
      chk("midrst_res", result, 32'h0);
      chk("midrst_busy_done", {30'b0, busy, done}, 32'h0);
      @(negedge clk) rst = 1'b0;
      seen = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done === 1'b1) seen++;
      end
      chk("midrst_no_done", seen, 0);
      run_op(4'b0000, 32'd2, 32'd3, lat, bc);
      chk("post_rst_lat", lat, 1);
      chk("post_rst_res", result, 32'd5);

      // start held high: one single-cycle result per cycle.
      @(negedge clk);
      start = 1'b1; alu_op = 4'b0000; a = 32'd1; b = 32'd1;
      @(posedge clk); #1;
      chk("b2b_1", {done, result[30:0]}, 32'h8000_0002);
      @(negedge clk);
      alu_op = 4'b0001; a = 32'd7; b = 32'd3;
      @(posedge clk); #1;
      chk("b2b_2", {done, result[30:0]}, 32'h8000_0004);
      @(negedge clk) start = 1'b0;
      @(posedge clk); #1;
      chk("hold_done", {31'b0, done}, 32'h0);
      chk("hold_res", result, 32'd4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/alu_multicycle.md
Name: alu_multicycle

Overview:
Execution unit that consumes the 4-bit ALU operation code produced by the ALU control decoder, together with two 32-bit operands. It executes the operation and returns the result through a start/busy/done handshake. Logic ops, ADD/SUB, shift and compare complete in 1 cycle. MUL uses an iterative 32-step shift-add datapath and DIV uses an iterative 32-step restoring datapath. The block sits in the EX stage, and the pipeline controller stalls on busy.

Parameters:
WIDTH, 32, operand/result width (only 32 supported; shift amount = b[4:0])
ITER, 32, MUL/DIV iteration count (must equal WIDTH)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-high
start  input  1  single-cycle request; sampled only in IDLE
alu_op  input  4  op code: 0000 ADD, 0001 SUB, 0010 MUL, 0011 DIV, 0100 AND, 0101 OR, 0110 NOR, 0111 NOP, 1000 SRL, 1001 SLT, 1010 XOR
a  input  32  operand A (rs)
b  input  32  operand B (rt / shift amount)
busy  output  1  high while MUL/DIV in flight
done  output  1  one-cycle pulse; result/flags valid
result  output  32  main result (MUL low word, DIV quotient)
result_hi  output  32  MUL high word / DIV remainder; 0 for other ops
zero  output  1  result == 0
ovf  output  1  signed overflow (ADD/SUB only)
div0  output  1  DIV with b == 0
illegal  output  1  op code 1011..1111

Behaviour:
- Reset (async, rst=1): state IDLE; busy, done, zero, ovf, div0 and illegal = 0; result and result_hi = 0; iteration counter = 0. Reset mid-MUL/DIV abandons the operation with no done pulse.
- States: IDLE, MUL_RUN, DIV_RUN, FINISH.
- IDLE, start=1, single-cycle op: the result is registered at the same edge. done=1 for exactly the next cycle. Latency 1. State stays IDLE.
- Single-cycle op semantics:
  - ADD/SUB: wrap modulo 2^32.
  - ovf: set when operand signs match (ADD) or differ (SUB) and the result sign differs from a.
  - AND, OR, NOR, XOR: bitwise.
  - SRL: a >> b[4:0], zero fill.
  - SLT: signed a < b gives 1, else 0.
  - NOP: result 0, done still pulses.
- IDLE, start=1, MUL/DIV: a and b are captured. State goes to MUL_RUN/DIV_RUN with busy=1 and the counter cleared.
- Run states: the operation is on operand magnitudes; one iteration per cycle for ITER cycles, then FINISH.
- FINISH (1 cycle):
  - Applies sign correction and registers result, result_hi and flags.
  - done=1 for one cycle and busy=0 in that same cycle. Next state is IDLE.
  - Total latency start-edge to done = ITER+2 = 34 cycles.
- MUL: signed 64-bit product; result = low word, result_hi = high word.
- DIV: signed; quotient truncates toward zero; remainder takes the sign of a.
- DIV with b=0: no iteration. The next state is FINISH directly, giving latency 2.
  - result = 0xFFFFFFFF, result_hi = a, div0 = 1.
- DIV overflow: 0x80000000 / -1 gives result = 0x80000000, result_hi = 0. ovf stays 0.
- Illegal op code: 1-cycle completion, result = 0, result_hi = 0, illegal = 1.
- Flag updates: zero reflects the main result for every op. ovf, div0 and illegal are cleared on any op that does not set them.
- Register hold: result, result_hi and flags update only on completion and hold between operations.
- start while busy or in FINISH: ignored, no queuing.
- Operand changes during busy have no effect.
- done and busy are never high together.
- start held high continuously: a new op is accepted in every IDLE cycle. For single-cycle ops this gives back-to-back done pulses, one result per cycle.

Test Plan:
- ADD a=0x7FFFFFFF, b=1 -> done 1 cycle after start; result=0x80000000, ovf=1, zero=0.
- SUB a=5, b=5 -> result=0, zero=1, ovf=0. SLT a=0xFFFFFFFF, b=1 -> result=1. SRL a=0x80000000, b=31 -> result=1.
- MUL a=-3, b=7 -> busy for 33 cycles; done at cycle 34; result=0xFFFFFFEB, result_hi=0xFFFFFFFF. MUL 0xFFFFFFFF*0xFFFFFFFF -> result=1, result_hi=0.
- DIV a=-7, b=2 -> result=0xFFFFFFFD, result_hi=0xFFFFFFFF, done at 34. DIV a=9, b=0 -> done at 2, result=0xFFFFFFFF, result_hi=9, div0=1.
- Start a MUL, then pulse start with ADD at cycle 10 -> ADD ignored, MUL result correct. Assert rst at cycle 20 of a second MUL -> outputs 0, no done, a new ADD completes normally afterwards.
- alu_op=1111 -> done after 1 cycle, result=0, illegal=1. The next legal op clears illegal.
